coef_bank_sched: RTL

Coefficient-bank scheduler for the FIR datapath. It sits between the host coefficient-write port, the FIR MAC engine and the four 16-entry coefficient SRAM banks, and it owns every SRAM strobe. On each new-sample start it sequences a 16-cycle parallel read of all four banks, which feeds four MAC lanes. Host coefficient writes are buffered and slotted in only while the banks are not being read.

---
 rtl/coef_sched_pkg.sv | 17 +
 rtl/coef_bank_sched_if.sv | 43 ++++
 rtl/coef_bank_sel.sv | 43 ++++
 rtl/coef_bank_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/coef_sched_pkg.sv
// Shared types and constants for the coefficient-bank scheduler.
package coef_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHost
    } state_e;

    localparam int unsigned NUM_BANK = 4;
    localparam int unsigned RD_LAT   = 1;

    // Active-low strobes: all ones means no bank selected.
    localparam logic [NUM_BANK-1:0] STROBE_IDLE = '1;

endpackage

// File: rtl/coef_bank_sched_if.sv
// Host write port, FIR start/read-qualifier and SRAM bank strobes of the scheduler.
interface coef_bank_sched_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              iHostCsn;
    logic              iHostWrn;
    logic [ADDR_W+1:0] iHostAddr;
    logic [DATA_W-1:0] iHostData;
    logic              oHostRdy;
    logic              oHostAck;
    logic              iFirStart;
    logic              oFirBusy;
    logic              oRdValid;
    logic              oRdLast;
    logic [ADDR_W-1:0] oTapIdx;
    logic              oCsn_1;
    logic              oCsn_2;
    logic              oCsn_3;
    logic              oCsn_4;
    logic              oWrn_1;
    logic              oWrn_2;
    logic              oWrn_3;
    logic              oWrn_4;
    logic [ADDR_W-1:0] oAddr;
    logic [DATA_W-1:0] oWrData;
    logic              oErr;

    modport slave (
        input  iHostCsn, iHostWrn, iHostAddr, iHostData, iFirStart,
        output oHostRdy, oHostAck, oFirBusy, oRdValid, oRdLast, oTapIdx,
        output oCsn_1, oCsn_2, oCsn_3, oCsn_4, oWrn_1, oWrn_2, oWrn_3, oWrn_4,
        output oAddr, oWrData, oErr
    );

    modport master (
        output iHostCsn, iHostWrn, iHostAddr, iHostData, iFirStart,
        input  oHostRdy, oHostAck, oFirBusy, oRdValid, oRdLast, oTapIdx,
        input  oCsn_1, oCsn_2, oCsn_3, oCsn_4, oWrn_1, oWrn_2, oWrn_3, oWrn_4,
        input  oAddr, oWrData, oErr
    );

endinterface

// File: rtl/coef_bank_sel.sv
// Registered active-low bank strobe generator: one bank for a write, all banks for a read.
module coef_bank_sel
    import coef_sched_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                wr_i,
    input  logic [1:0]          bank_i,
    output logic [NUM_BANK-1:0] csn_o,
    output logic [NUM_BANK-1:0] wrn_o
);

    logic [NUM_BANK-1:0] csn_d, csn_q;
    logic [NUM_BANK-1:0] wrn_d, wrn_q;

    always_comb begin
        csn_d = STROBE_IDLE;
        wrn_d = STROBE_IDLE;
        if (en_i) begin
            if (wr_i) begin
                csn_d[bank_i] = 1'b0;
                wrn_d[bank_i] = 1'b0;
            end else begin
                csn_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csn_q <= STROBE_IDLE;
            wrn_q <= STROBE_IDLE;
        end else begin
            csn_q <= csn_d;
            wrn_q <= wrn_d;
        end
    end

    assign csn_o = csn_q;
    assign wrn_o = wrn_q;

endmodule

// File: rtl/coef_bank_sched.sv
// Coefficient-bank scheduler: sequences 16-tap parallel reads of four SRAM banks on each
// FIR start and slots buffered host coefficient writes into the gaps between read runs.
module coef_bank_sched
    import coef_sched_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    coef_bank_sched_if.slave bus_io
);

    localparam int unsigned       TAPS     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              buf_vld_q, buf_vld_d;
    logic [1:0]        buf_bank_q, buf_bank_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;

    logic [RD_LAT-1:0]             vld_pipe_q;
    logic [RD_LAT-1:0]             last_pipe_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] tap_pipe_q;

    logic              host_req, req_acc, req_drop;
    logic              start_nidle, start_drop, start_pend, consume;
    logic              host_full;
    logic [1:0]        eff_bank;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_data;
    logic              sel_en, sel_wr;
    logic [NUM_BANK-1:0] csn, wrn;

    // A request arriving this cycle counts as buffered so IDLE/DRAIN can issue it next cycle.
    always_comb begin
        host_req    = ~bus_io.iHostCsn & ~bus_io.iHostWrn;
        req_acc     = host_req & ~buf_vld_q;
        req_drop    = host_req & buf_vld_q;
        host_full   = buf_vld_q | req_acc;
        start_nidle = bus_io.iFirStart & (state_q != StIdle);
        start_drop  = start_nidle & pend_q;
        start_pend  = pend_q | start_nidle;
        eff_bank    = buf_vld_q ? buf_bank_q : bus_io.iHostAddr[ADDR_W+1:ADDR_W];
        eff_addr    = buf_vld_q ? buf_addr_q : bus_io.iHostAddr[ADDR_W-1:0];
        eff_data    = buf_vld_q ? buf_data_q : bus_io.iHostData;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        consume = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.iFirStart) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (host_full) begin
                    state_d = StHost;
                end
            end
            StRun: begin
                if (cnt_q == LAST_TAP) begin
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (host_full) begin
                    state_d = StHost;
                end else if (start_pend) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    consume = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StHost: begin
                if (start_pend) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    consume = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_bank_d = buf_bank_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (state_q == StHost) begin
            buf_vld_d = 1'b0;
        end else if (req_acc) begin
            buf_vld_d  = 1'b1;
            buf_bank_d = bus_io.iHostAddr[ADDR_W+1:ADDR_W];
            buf_addr_d = bus_io.iHostAddr[ADDR_W-1:0];
            buf_data_d = bus_io.iHostData;
        end
        pend_d = consume ? 1'b0 : start_pend;
        err_d  = err_q | req_drop | start_drop;
    end

    // Outputs are registered from the next state so strobes line up with the state cycle.
    always_comb begin
        sel_en    = (state_d == StRun) || (state_d == StHost);
        sel_wr    = (state_d == StHost);
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        if (state_d == StRun) begin
            addr_d = cnt_d;
        end else if (state_d == StHost) begin
            addr_d    = eff_addr;
            wr_data_d = eff_data;
        end
        busy_d = (state_d == StRun) || (state_d == StDrain);
        ack_d  = (state_d == StHost);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            buf_vld_q  <= 1'b0;
            buf_bank_q <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_vld_q  <= buf_vld_d;
            buf_bank_q <= buf_bank_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    // Read-data qualifier delayed by the SRAM read latency behind each issued read.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            tap_pipe_q  <= '0;
        end else begin
            vld_pipe_q[0]  <= (state_q == StRun);
            last_pipe_q[0] <= (state_q == StRun) && (cnt_q == LAST_TAP);
            tap_pipe_q[0]  <= cnt_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
                tap_pipe_q[i]  <= tap_pipe_q[i-1];
            end
        end
    end

    coef_bank_sel u_bank_sel (
        .clk_i  (iClk),
        .rst_i  (iRst),
        .en_i   (sel_en),
        .wr_i   (sel_wr),
        .bank_i (eff_bank),
        .csn_o  (csn),
        .wrn_o  (wrn)
    );

    assign bus_io.oCsn_1   = csn[0];
    assign bus_io.oCsn_2   = csn[1];
    assign bus_io.oCsn_3   = csn[2];
    assign bus_io.oCsn_4   = csn[3];
    assign bus_io.oWrn_1   = wrn[0];
    assign bus_io.oWrn_2   = wrn[1];
    assign bus_io.oWrn_3   = wrn[2];
    assign bus_io.oWrn_4   = wrn[3];
    assign bus_io.oAddr    = addr_q;
    assign bus_io.oWrData  = wr_data_q;
    assign bus_io.oHostRdy = ~buf_vld_q;
    assign bus_io.oHostAck = ack_q;
    assign bus_io.oFirBusy = busy_q;
    assign bus_io.oRdValid = vld_pipe_q[RD_LAT-1];
    assign bus_io.oRdLast  = last_pipe_q[RD_LAT-1];
    assign bus_io.oTapIdx  = tap_pipe_q[RD_LAT-1];
    assign bus_io.oErr     = err_q;

endmodule
